// File: rtl/trig_seq_gen_mc.sv
// trig_seq_gen_mc: multi-channel trigger sequence generator (Num ticks, Step apart, fanned out to CH_NUM delayed pulse outputs)
// Ports: I_clk/I_Rst_n clock and async active-low reset; I_Trig_in start (rising edge); I_Abort sync abort;
//        I_Trig_Num/I_Trig_Step/I_Pulse_Len/I_Ch_En/I_Ch_Dly sequence setup latched at start;
//        O_Trig per-channel outputs; O_Busy/O_Done status; O_Tick_Cnt ticks issued; O_Ovf sticky overrun flags.
// Optional: define TRIG_GEN_CH_DLY_EN to build per-channel delays and overrun flags (otherwise delay 0, O_Ovf=0).
module trig_seq_gen_mc #(
    parameter int CH_NUM = 17,
    parameter int CNT_W  = 32,
    parameter int DLY_W  = 16,
    parameter int PLEN_W = 8
) (
    input  logic                    I_clk,
    input  logic                    I_Rst_n,
    input  logic                    I_Trig_in,
    input  logic                    I_Abort,
    input  logic [CNT_W-1:0]        I_Trig_Num,
    input  logic [CNT_W-1:0]        I_Trig_Step,
    input  logic [PLEN_W-1:0]       I_Pulse_Len,
    input  logic [CH_NUM-1:0]       I_Ch_En,
    input  logic [CH_NUM*DLY_W-1:0] I_Ch_Dly,
    output logic [CH_NUM-1:0]       O_Trig,
    output logic                    O_Busy,
    output logic                    O_Done,
    output logic [CNT_W-1:0]        O_Tick_Cnt,
    output logic [CH_NUM-1:0]       O_Ovf
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    logic [1:0] state, nxt;
    logic trig_q, trig_qq, start, tick, busy_q, done_q;
    logic [CNT_W-1:0] num_r, step_m1, scnt, tcnt;
    logic [PLEN_W-1:0] len_m1;
    logic [CH_NUM-1:0] en_r, ch_idle;
`ifdef TRIG_GEN_CH_DLY_EN
    logic [CH_NUM*DLY_W-1:0] dly_r;
`else
    logic unused_dly;
    assign unused_dly = ^I_Ch_Dly;
    assign O_Ovf = '0;
`endif
    // the edge is taken from the registered copy, so RUN starts one clock after the first high sample
    assign start = state == IDLE && trig_q && !trig_qq && I_Trig_Num != '0 && !I_Abort;
    assign tick  = state == RUN && scnt == '0 && !I_Abort;
    assign O_Busy = busy_q;
    assign O_Done = done_q;
    assign O_Tick_Cnt = tcnt;
    always_comb
        nxt = I_Abort ? IDLE :
              state == IDLE ? (start ? RUN : IDLE) :
              state == RUN ? ((tick && tcnt + CNT_W'(1) == num_r) ? DRAIN : RUN) :
              state == DRAIN ? (&ch_idle ? DONE : DRAIN) : IDLE;
    always_ff @(posedge I_clk or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            state   <= IDLE;
            trig_q  <= 1'b0;
            trig_qq <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            num_r   <= '0;
            step_m1 <= '0;
            len_m1  <= '0;
            en_r    <= '0;
            scnt    <= '0;
            tcnt    <= '0;
`ifdef TRIG_GEN_CH_DLY_EN
            dly_r   <= '0;
`endif
        end else begin
            trig_q  <= I_Trig_in;
            trig_qq <= trig_q;
            state   <= nxt;
            busy_q  <= nxt != IDLE;
            done_q  <= nxt == DONE;
            if (start) begin
                num_r   <= I_Trig_Num;
                step_m1 <= I_Trig_Step == '0 ? '0 : I_Trig_Step - CNT_W'(1);
                len_m1  <= I_Pulse_Len == '0 ? '0 : I_Pulse_Len - PLEN_W'(1);
                en_r    <= I_Ch_En;
                tcnt    <= '0;
                scnt    <= '0;
`ifdef TRIG_GEN_CH_DLY_EN
                dly_r   <= I_Ch_Dly;
`endif
            end else if (tick) begin
                tcnt <= tcnt + CNT_W'(1);
                scnt <= step_m1;
            end else if (state == RUN && scnt != '0) begin
                scnt <= scnt - CNT_W'(1);
            end
        end
    end
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [PLEN_W-1:0] pcnt;
        logic trig, fire, tick_ch;
        assign tick_ch = tick && en_r[i];
        assign O_Trig[i] = trig;
`ifdef TRIG_GEN_CH_DLY_EN
        logic pend, ovf;
        logic [DLY_W-1:0] dcnt, dly;
        assign dly = dly_r[i*DLY_W +: DLY_W];
        // a new tick overrides a pending fire, so the pending path only fires on non-tick cycles
        assign fire = tick_ch ? dly == '0 : pend && dcnt == '0;
        assign ch_idle[i] = !pend && pcnt == '0;
        assign O_Ovf[i] = ovf;
        always_ff @(posedge I_clk or negedge I_Rst_n) begin
            if (!I_Rst_n) begin
                pend <= 1'b0;
                dcnt <= '0;
                ovf  <= 1'b0;
            end else begin
                if (start)
                    ovf <= 1'b0;
                else if (tick_ch && pend)
                    ovf <= 1'b1;
                if (I_Abort) begin
                    pend <= 1'b0;
                    dcnt <= '0;
                end else if (tick_ch && dly != '0) begin
                    pend <= 1'b1;
                    dcnt <= dly - DLY_W'(1);
                end else if (pend) begin
                    if (dcnt == '0)
                        pend <= 1'b0;
                    else
                        dcnt <= dcnt - DLY_W'(1);
                end
            end
        end
`else
        assign fire = tick_ch;
        assign ch_idle[i] = pcnt == '0;
`endif
        // pcnt holds the clocks remaining after the current high one; a refire reloads it without a gap
        always_ff @(posedge I_clk or negedge I_Rst_n) begin
            if (!I_Rst_n) begin
                trig <= 1'b0;
                pcnt <= '0;
            end else if (I_Abort) begin
                trig <= 1'b0;
                pcnt <= '0;
            end else if (fire) begin
                trig <= 1'b1;
                pcnt <= len_m1;
            end else if (pcnt != '0) begin
                pcnt <= pcnt - PLEN_W'(1);
            end else begin
                trig <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_trig_seq_gen_mc.sv
// tb_trig_seq_gen_mc: scoreboard bench; expected output-change events are queued at stimulus time, a monitor pops and compares them
module tb_trig_seq_gen_mc;
    localparam int CH = 17;
    localparam logic [CH-1:0] ALL = 17'h1FFFF;
    logic clk = 1'b0;
    logic rst_n, trig_in, abort;
    logic [31:0] num, step;
    logic [7:0] len;
    logic [CH-1:0] en;
    logic [CH*16-1:0] dly;
    logic [CH-1:0] o_trig, o_ovf;
    logic o_busy, o_done;
    logic [31:0] o_tcnt;
    int cyc = 0;
    int e_cyc = 0;
    int checks = 0;
    int errors = 0;
    typedef struct {
        int cyc;
        logic [CH-1:0] trig;
        logic done;
        logic [31:0] tcnt;
    } ev_t;
    ev_t sb[$];

    trig_seq_gen_mc dut (
        .I_clk(clk), .I_Rst_n(rst_n), .I_Trig_in(trig_in), .I_Abort(abort),
        .I_Trig_Num(num), .I_Trig_Step(step), .I_Pulse_Len(len), .I_Ch_En(en), .I_Ch_Dly(dly),
        .O_Trig(o_trig), .O_Busy(o_busy), .O_Done(o_done), .O_Tick_Cnt(o_tcnt), .O_Ovf(o_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic ev(input int c, input logic [CH-1:0] t, input logic d = 1'b0, input logic [31:0] n = 0);
        ev_t e;
        e.cyc = c;
        e.trig = t;
        e.done = d;
        e.tcnt = n;
        sb.push_back(e);
    endtask

    // one event per cycle where O_Trig changes or O_Done is high
    task automatic monitor();
        logic [CH-1:0] prev = '0;
        ev_t e;
        int rel;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = o_trig;
            end else if (o_trig != prev || o_done) begin
                rel = cyc - e_cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: rel=%0d trig=%h done=%b tcnt=%0d", rel, o_trig, o_done, o_tcnt);
                end else begin
                    e = sb.pop_front();
                    if (rel != e.cyc || o_trig !== e.trig || o_done !== e.done || (e.done && o_tcnt !== e.tcnt)) begin
                        errors++;
                        $display("FAIL event: got rel=%0d trig=%h done=%b tcnt=%0d expected rel=%0d trig=%h done=%b tcnt=%0d",
                                 rel, o_trig, o_done, o_tcnt, e.cyc, e.trig, e.done, e.tcnt);
                    end
                end
                prev = o_trig;
            end
        end
    endtask

    task automatic setup(input int n, input int s, input int l, input logic [CH-1:0] e);
        num = n;
        step = s;
        len = l[7:0];
        en = e;
        dly = '0;
    endtask

    // returns at the negedge after edge E (rel 0), with I_Trig_in back low
    task automatic start();
        trig_in = 1'b0;
        repeat (3) @(negedge clk);
        e_cyc = cyc + 1;
        trig_in = 1'b1;
        @(negedge clk);
        trig_in = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - e_cyc < n) @(negedge clk);
    endtask

    task automatic drain(input string nm, input int max);
        for (int i = 0; i < max && (sb.size() != 0 || o_busy); i++) @(negedge clk);
        @(negedge clk);
        chk({nm, "_events_left"}, sb.size(), 0);
        chk({nm, "_busy_end"}, o_busy, 0);
    endtask

    task automatic run_basic(input string nm);
        setup(3, 10, 2, ALL);
        ev(2, ALL); ev(4, '0); ev(12, ALL); ev(14, '0); ev(22, ALL); ev(24, '0, 1'b1, 3);
        start();
        wait_rel(1);
        chk({nm, "_busy_e1"}, o_busy, 1);
        drain(nm, 80);
        chk({nm, "_tick_cnt"}, o_tcnt, 3);
    endtask

    initial begin
        logic busy_seen;
        logic [CH-1:0] exp_ovf;
        rst_n = 1'b0;
        trig_in = 1'b0;
        abort = 1'b0;
        setup(0, 0, 0, '0);
        repeat (3) @(negedge clk);
        chk("rst_trig", o_trig, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_tcnt", o_tcnt, 0);
        chk("rst_ovf", o_ovf, 0);
        rst_n = 1'b1;
        fork
            monitor();
        join_none

        run_basic("basic");

        setup(2, 8, 1, 17'h21);
        dly[5*16 +: 16] = 16'd4;
`ifdef TRIG_GEN_CH_DLY_EN
        ev(2, 17'h01); ev(3, '0); ev(6, 17'h20); ev(7, '0);
        ev(10, 17'h01); ev(11, '0); ev(14, 17'h20); ev(15, '0, 1'b1, 2);
`else
        ev(2, 17'h21); ev(3, '0); ev(10, 17'h21); ev(11, '0, 1'b1, 2);
`endif
        start();
        drain("delay", 80);

        setup(4, 3, 1, 17'h03);
        dly[1*16 +: 16] = 16'd5;
`ifdef TRIG_GEN_CH_DLY_EN
        ev(2, 17'h1); ev(3, '0); ev(5, 17'h1); ev(6, '0); ev(8, 17'h1); ev(9, '0);
        ev(11, 17'h1); ev(12, '0); ev(16, 17'h2); ev(17, '0, 1'b1, 4);
        exp_ovf = 17'h2;
`else
        ev(2, 17'h3); ev(3, '0); ev(5, 17'h3); ev(6, '0); ev(8, 17'h3); ev(9, '0);
        ev(11, 17'h3); ev(12, '0, 1'b1, 4);
        exp_ovf = '0;
`endif
        start();
        drain("overrun", 80);
        chk("overrun_ovf", o_ovf, exp_ovf);

        setup(0, 5, 1, ALL);
        start();
        busy_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            busy_seen |= o_busy;
        end
        chk("num0_busy", busy_seen, 0);
        chk("num0_tcnt_held", o_tcnt, 4);

        setup(3, 0, 0, ALL);
        ev(2, ALL); ev(5, '0, 1'b1, 3);
        start();
        drain("degenerate", 40);

        setup(100, 5, 2, ALL);
        for (int k = 0; k < 6; k++) begin
            ev(2 + 5 * k, ALL);
            ev(4 + 5 * k, '0);
        end
        ev(32, ALL); ev(33, '0);
        start();
        wait_rel(32);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_trig", o_trig, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        chk("abort_tcnt", o_tcnt, 7);
        repeat (5) @(negedge clk);
        chk("abort_events_left", sb.size(), 0);
        run_basic("after_abort");

        setup(3, 4, 1, ALL);
        ev(2, ALL); ev(3, '0); ev(6, ALL); ev(7, '0); ev(10, ALL); ev(11, '0, 1'b1, 3);
        start();
        wait_rel(4);
        trig_in = 1'b1;
        drain("retrig", 60);
        chk("retrig_tcnt", o_tcnt, 3);
        trig_in = 1'b0;

        setup(3, 10, 2, ALL);
        ev(2, ALL);
        start();
        wait_rel(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_trig", o_trig, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_done", o_done, 0);
        chk("arst_tcnt", o_tcnt, 0);
        chk("arst_ovf", o_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_events_left", sb.size(), 0);
        run_basic("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
